// File: rtl/dpram_port_master.sv
// rtl/dpram_port_master.sv - one-port controller for dpram: read, write, atomic set/clear with response channel
// Optional post-reset zero sweep of the whole RAM: define DPRAM_MASTER_ZERO_INIT_EN.
module dpram_port_master #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [1:0]            req_op_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_data_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_data_o,
   output logic                  mem_wen_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_data_o,
   input  logic [DATA_WIDTH-1:0] mem_q_i
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_RESP  = 3'd3;
`ifdef DPRAM_MASTER_ZERO_INIT_EN
   localparam logic [2:0] S_INIT  = 3'd4;
   localparam logic [2:0] S_RESET = S_INIT;
   localparam logic [ADDR_WIDTH:0] INIT_LAST = {1'b0, {ADDR_WIDTH{1'b1}}};
`else
   localparam logic [2:0] S_RESET = S_IDLE;
`endif

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_SET   = 2'b10;
   localparam logic [1:0] OP_CLR   = 2'b11;

   logic [2:0]            state_q, state_d;
   logic [1:0]            op_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic                  wen;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  accept;

   assign req_ready_o = rst_n_i && (state_q == S_IDLE);
   assign rsp_valid_o = rst_n_i && (state_q == S_RESP);
   assign rsp_data_o  = rsp_data_q;
   assign accept      = req_valid_i && req_ready_o;

`ifdef DPRAM_MASTER_ZERO_INIT_EN
   logic [ADDR_WIDTH:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else if (state_q == S_INIT) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign mem_addr_o = (state_q == S_INIT) ? cnt_q[ADDR_WIDTH-1:0] : addr_q;
`else
   assign mem_addr_o = addr_q;
`endif

   // WAIT is the only cycle mem_q is meaningful; the RMW writeback is formed from it directly
   always_comb begin
      state_d    = state_q;
      rsp_data_d = rsp_data_q;
      wen        = 1'b0;
      wdata      = '0;
      case (state_q)
         S_IDLE: begin
            if (req_valid_i) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            if (op_q == OP_WRITE) begin
               wen     = 1'b1;
               wdata   = data_q;
               state_d = S_IDLE;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            rsp_data_d = mem_q_i;
            state_d    = S_RESP;
            if (op_q == OP_SET) begin
               wen   = 1'b1;
               wdata = mem_q_i | data_q;
            end else if (op_q == OP_CLR) begin
               wen   = 1'b1;
               wdata = mem_q_i & ~data_q;
            end
         end
         S_RESP: begin
            if (rsp_ready_i) state_d = S_IDLE;
         end
`ifdef DPRAM_MASTER_ZERO_INIT_EN
         S_INIT: begin
            wen = 1'b1;
            if (cnt_q == INIT_LAST) state_d = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // Reset gates the write strobe so an interrupted RMW never reaches the RAM
   assign mem_wen_o  = rst_n_i && wen;
   assign mem_data_o = rst_n_i ? wdata : '0;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q    <= S_RESET;
         op_q       <= OP_READ;
         addr_q     <= '0;
         data_q     <= '0;
         rsp_data_q <= '0;
      end else begin
         state_q    <= state_d;
         rsp_data_q <= rsp_data_d;
         if (accept) begin
            op_q   <= req_op_i;
            addr_q <= req_addr_i;
            data_q <= req_data_i;
         end
      end
   end

endmodule

// File: tb/tb_dpram_port_master.sv
// tb/tb_dpram_port_master.sv - randomized bench for dpram_port_master with a cycle-level reference model
// Honours DPRAM_MASTER_ZERO_INIT_EN when the design is built with it.
module tb_dpram_port_master;

   localparam int DW = 64;
   localparam int AW = 6;
   localparam int DEPTH = 1 << AW;
   localparam logic [1:0] RD = 2'b00, WR = 2'b01, ST = 2'b10, CL = 2'b11;
`ifdef DPRAM_MASTER_ZERO_INIT_EN
   localparam int INIT_CYCLES = DEPTH;
`else
   localparam int INIT_CYCLES = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [1:0]    req_op = RD;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_data = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [DW-1:0] rsp_data;
   logic          mem_wen;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic [DW-1:0] mem_q = '0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dpram_port_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
      .req_addr_i(req_addr), .req_data_i(req_data),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
      .mem_wen_o(mem_wen), .mem_addr_o(mem_addr), .mem_data_o(mem_data), .mem_q_i(mem_q)
   );

   function automatic logic [DW-1:0] fill_val(input int i);
`ifdef DPRAM_MASTER_ZERO_INIT_EN
      fill_val = '1;
`else
      fill_val = {32'h5EED0000 | i, 32'hC0DE0000 | (i * 7)};
`endif
   endfunction

   // Bench RAM: registered read, read-before-write
   logic [DW-1:0] ram [DEPTH];
   bit filled = 1'b0;
   always @(posedge clk) begin
      if (!filled) begin
         for (int i = 0; i < DEPTH; i++) ram[i] <= fill_val(i);
         filled <= 1'b1;
      end else begin
         if (mem_wen) ram[mem_addr] <= mem_data;
         mem_q <= ram[mem_addr];
      end
   end

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   // Reference model: memory contents plus the transaction in flight, tracked by its age in cycles
   logic [DW-1:0] ref_mem [DEPTH];
   initial for (int i = 0; i < DEPTH; i++) ref_mem[i] = fill_val(i);

   int            ncyc = 0;
   int            acc_cyc = 0;
   bit            busy = 1'b0;
   int            init_left = 0;
   logic [1:0]    acc_op = RD;
   logic [AW-1:0] acc_addr = '0;
   logic [DW-1:0] acc_data = '0;
   logic [DW-1:0] exp_rsp = '0;

   always @(negedge clk) begin
      bit            exp_ready, exp_valid, exp_wen, finish_now;
      logic [AW-1:0] exp_waddr;
      logic [DW-1:0] exp_wdata, pre;
      int            age;
      ncyc++;
      if (!rst_n) begin
         chk("reset req_ready", {63'b0, req_ready}, 0);
         chk("reset rsp_valid", {63'b0, rsp_valid}, 0);
         chk("reset mem_wen", {63'b0, mem_wen}, 0);
         busy = 1'b0;
         init_left = INIT_CYCLES;
      end else begin
         exp_ready = !busy && (init_left == 0);
         exp_valid = 1'b0;
         exp_wen = 1'b0;
         exp_waddr = '0;
         exp_wdata = '0;
         finish_now = 1'b0;
         if (init_left > 0) begin
            exp_wen = 1'b1;
            exp_waddr = AW'(DEPTH - init_left);
            ref_mem[exp_waddr] = '0;
            init_left--;
         end else if (busy) begin
            age = ncyc - acc_cyc;
            if (age == 1) begin
               chk("issue mem_addr", {58'b0, mem_addr}, {58'b0, acc_addr});
               if (acc_op == WR) begin
                  exp_wen = 1'b1;
                  exp_waddr = acc_addr;
                  exp_wdata = acc_data;
                  ref_mem[acc_addr] = acc_data;
                  finish_now = 1'b1;
               end
            end else if (age == 2) begin
               pre = ref_mem[acc_addr];
               exp_rsp = pre;
               if (acc_op != RD) begin
                  exp_wen = 1'b1;
                  exp_waddr = acc_addr;
                  exp_wdata = (acc_op == ST) ? (pre | acc_data) : (pre & ~acc_data);
                  ref_mem[acc_addr] = exp_wdata;
               end
            end else begin
               exp_valid = 1'b1;
               chk("rsp_data", rsp_data, exp_rsp);
               if (rsp_ready) finish_now = 1'b1;
            end
         end
         chk("req_ready", {63'b0, req_ready}, {63'b0, exp_ready});
         chk("rsp_valid", {63'b0, rsp_valid}, {63'b0, exp_valid});
         chk("mem_wen", {63'b0, mem_wen}, {63'b0, exp_wen});
         if (exp_wen) chk("write mem_addr", {58'b0, mem_addr}, {58'b0, exp_waddr});
         chk("mem_data", mem_data, exp_wdata);
         if (req_valid && exp_ready) begin
            busy = 1'b1;
            acc_cyc = ncyc;
            acc_op = req_op;
            acc_addr = req_addr;
            acc_data = req_data;
         end
         if (finish_now) busy = 1'b0;
      end
   end

   // All driving happens 1 time unit after a rising edge
   task automatic do_req(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int stall, output logic [DW-1:0] r);
      int n;
      r = '0;
      rsp_ready = (stall == 0);
      req_op = op;
      req_addr = a;
      req_data = d;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 200) begin @(posedge clk); #1; n++; end
      if (!req_ready) begin
         timeout("req accept");
         req_valid = 1'b0;
      end else begin
         @(posedge clk); #1;
         req_valid = 1'b0;
         if (op != WR) begin
            n = 0;
            while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
            if (!rsp_valid) timeout("rsp_valid");
            r = rsp_data;
            repeat (stall) begin @(posedge clk); #1; end
            rsp_ready = 1'b1;
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      logic [DW-1:0] r;
      logic [DW-1:0] exp7;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

`ifdef DPRAM_MASTER_ZERO_INIT_EN
      do_req(RD, 6'd0, '0, 0, r);
      chk("init read 0", r, 64'h0);
      do_req(RD, 6'd63, '0, 0, r);
      chk("init read 63", r, 64'h0);
`endif
      do_req(WR, 6'd5, 64'h0000_0000_DEAD_BEEF, 0, r);
      do_req(RD, 6'd5, '0, 0, r);
      chk("read 5", r, 64'h0000_0000_DEAD_BEEF);

      do_req(WR, 6'd3, 64'h0F, 0, r);
      do_req(ST, 6'd3, 64'hF0, 0, r);
      chk("set old", r, 64'h0F);
      do_req(RD, 6'd3, '0, 0, r);
      chk("set result", r, 64'hFF);

      do_req(CL, 6'd3, 64'h0F, 0, r);
      chk("clr old", r, 64'hFF);
      do_req(RD, 6'd3, '0, 5, r);
      chk("clr result stalled", r, 64'hF0);

      do_req(WR, 6'd63, 64'hA5, 0, r);
      do_req(ST, 6'd63, 64'h0, 0, r);
      chk("set mask 0", r, 64'hA5);
      do_req(WR, 6'd0, 64'h5A, 0, r);
      do_req(CL, 6'd0, '1, 0, r);
      chk("clr all ones", r, 64'h5A);
      do_req(RD, 6'd0, '0, 0, r);
      chk("clr all ones result", r, 64'h0);

      // Reset lands in the WAIT cycle of a SET
      do_req(WR, 6'd7, 64'h1, 0, r);
      req_op = ST; req_addr = 6'd7; req_data = 64'h2; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
`ifdef DPRAM_MASTER_ZERO_INIT_EN
      exp7 = 64'h0;
`else
      exp7 = 64'h1;
`endif
      do_req(RD, 6'd7, '0, 0, r);
      chk("abort read 7", r, exp7);

      for (int k = 0; k < 200; k++) begin
         logic [1:0]    op;
         logic [AW-1:0] a;
         int            st;
         op = 2'($urandom_range(0, 3));
         a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1)) : AW'($urandom_range(0, 7));
         st = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         do_req(op, a, {$urandom, $urandom}, st, r);
      end

      repeat (4) begin @(posedge clk); #1; end
      for (int i = 0; i < DEPTH; i++) chk($sformatf("ram[%0d]", i), ram[i], ref_mem[i]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/dpram_port_master.md
# dpram_port_master

Request-side controller that owns one port of the dual-port table RAM (`dpram`) and turns valid/ready requests into RAM port activity. It supports plain read, plain write and atomic bit-set / bit-clear read-modify-write, hides the RAM's one-cycle read latency, and returns pre-operation data on a valid/ready response channel. MMU logic such as the page-table walker and the frame allocator instantiates one per RAM port.

## Interface
- `DATA_WIDTH`, 64, RAM word width.
- `ADDR_WIDTH`, 6, RAM address width; depth is 2^ADDR_WIDTH.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller accepts the request this cycle.
- `req_op`  in  2  00 READ, 01 WRITE, 10 SET (OR mask), 11 CLR (AND-NOT mask).
- `req_addr`  in  ADDR_WIDTH  target word.
- `req_data`  in  DATA_WIDTH  write data (WRITE) or bit mask (SET/CLR); ignored for READ.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_data`  out  DATA_WIDTH  word value before the operation.
- `mem_wen`  out  1  to RAM `wen`.
- `mem_addr`  out  ADDR_WIDTH  to RAM `addr`.
- `mem_data`  out  DATA_WIDTH  to RAM `data`.
- `mem_q`  in  DATA_WIDTH  from RAM `q` (registered, 1-cycle read latency).

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP, plus INIT when `DPRAM_MASTER_ZERO_INIT_EN` is defined.
- IDLE: `req_ready`=1. An accept (`req_valid && req_ready`) latches op, addr and data, then the FSM moves to ISSUE.
- ISSUE: `mem_addr`=latched addr.
  - WRITE: `mem_wen`=1, `mem_data`=latched data, next state IDLE. WRITE produces no response.
  - READ/SET/CLR: `mem_wen`=0, next state WAIT.
- WAIT: `mem_q` is valid and is captured into `rsp_data`.
  - SET: `mem_wen`=1, `mem_data`=`mem_q | mask`.
  - CLR: `mem_wen`=1, `mem_data`=`mem_q & ~mask`.
  - READ: `mem_wen`=0.
  - Next state RESP.
  - `mem_data` in WAIT is a combinational function of `mem_q`.
- RESP: `rsp_valid`=1. `rsp_data` stays stable until `rsp_ready`; then the FSM moves to IDLE.
- One request is in flight at a time. `req_ready`=0 in every state except IDLE.
- The other RAM port may be used concurrently. Same-address collisions across ports are the system's responsibility; atomicity is guaranteed only against this port's own traffic.
- Outside the write cycles listed above, `mem_wen`=0, `mem_addr` holds the last issued address, and `mem_data`=0.

## Timing
- While `rst_n`=0 at an edge: state goes to IDLE (or INIT); `rsp_data`, `mem_addr` and `mem_data` are set to 0. During the reset cycle, `req_ready`, `rsp_valid` and `mem_wen` are forced to 0.
- Accept at cycle N:
  - WRITE: `mem_wen` high in N+1; `req_ready` high again in N+2.
  - READ/SET/CLR: RAM read addressed in N+1; `mem_q` sampled in N+2; SET/CLR writeback in N+2; `rsp_valid` from N+3.
- Back-to-back rate: WRITE, one per 2 cycles; READ/SET/CLR, one per 4 cycles with `rsp_ready` held high.
- `rsp_ready` low stalls the FSM in RESP with all outputs held.
- Reset mid-operation: the operation is aborted and the response is lost. If reset hits WAIT, the writeback is suppressed and memory is unchanged.
- Mask values 0 (SET) and all-ones (CLR) are legal; they still perform the writeback cycle.

## Configuration
- `DPRAM_MASTER_ZERO_INIT_EN` defined:
  - After reset the FSM enters INIT.
  - INIT writes 0 to addresses 0..2^ADDR_WIDTH-1, one per cycle (`mem_wen`=1, `mem_data`=0), using an internal ADDR_WIDTH+1-bit counter.
  - `req_ready`=0 throughout INIT; IDLE follows after the last address.
  - Reset during INIT restarts the sweep at 0.
- Not defined: INIT and its counter are absent, and the FSM leaves reset directly in IDLE.

## Test plan
- WRITE addr 5 data 0x0000_0000_DEAD_BEEF, then READ addr 5 -> `mem_wen` high exactly 1 cycle for the write; `rsp_data`=0x...DEADBEEF with `rsp_valid` 3 cycles after the read accept.
- Preload addr 3 = 0x0F, SET mask 0xF0 -> `rsp_data`=0x0F; follow-up READ addr 3 returns 0xFF.
- Preload addr 3 = 0xFF, CLR mask 0x0F -> `rsp_data`=0xFF; follow-up READ returns 0xF0.
- `rsp_ready` held low 5 cycles during RESP -> `rsp_valid`/`rsp_data` stable and `req_ready`=0; on release, `req_ready`=1 the next cycle.
- Preload addr 7 = 0x1, SET mask 0x2, drop `rst_n` during WAIT -> no `mem_wen` pulse, no response; READ addr 7 afterwards returns 0x1.
- With `DPRAM_MASTER_ZERO_INIT_EN` and a RAM prefilled with 0xFF..FF -> `req_ready` low for 64 cycles after reset; READ addr 0 and addr 63 both return 0.
